// File: rtl/game_sequencer.sv
// Round controller for the game subsystem: enables one game at a time, counts its rounds,
// shows a win banner between games and a done banner after the last one.
module game_sequencer #(
  parameter int NUM_GAMES   = 3,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    score_pulse,
  input  logic [NUM_GAMES-1:0]    victory_in,
  input  logic [20*NUM_GAMES-1:0] game_bits_in,
  output logic [NUM_GAMES-1:0]    game_enable,
  output logic [2:0]              game_counter,
  output logic [2:0]              game_index,
  output logic [19:0]             bits,
  output logic                    all_done
);

  localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [2:0]    LAST_IDX   = 3'(NUM_GAMES - 1);
  localparam logic [19:0]   IDLE_PAT   = 20'b11111_10000_10000_11111;
  localparam logic [19:0]   WIN_PAT    = 20'b10000_10000_10000_10000;
  localparam logic [19:0]   DONE_PAT   = 20'b11111_11111_11111_11111;

  typedef enum logic [1:0] {IDLE, PLAY, WIN_HOLD, DONE} state_t;

  state_t                 state_q, state_d;
  logic [2:0]             index_q, index_d;
  logic [2:0]             counter_q, counter_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [NUM_GAMES-1:0]   enable_q, enable_d;
  logic [19:0]            bits_q, bits_d;
  logic                   done_q, done_d;
  logic                   victory_sel;
  logic [19:0]            game_sel;

  // Only the active game's victory flag is ever looked at.
  always_comb begin
    victory_sel = 1'b0;
    for (int i = 0; i < NUM_GAMES; i++) begin
      if (index_q == 3'(i)) victory_sel = victory_in[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    counter_d = counter_q;
    timer_d   = '0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = PLAY;
          index_d   = 3'd0;
          counter_d = 3'd0;
        end
      end
      PLAY: begin
        if (victory_sel) begin
          state_d   = WIN_HOLD;
          counter_d = 3'd0;
        end else if (score_pulse && counter_q != 3'd7) begin
          counter_d = counter_q + 3'd1;
        end
      end
      WIN_HOLD: begin
        if (timer_q == TIMER_LAST) begin
          if (index_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            state_d = PLAY;
            index_d = index_q + 3'd1;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d   = IDLE;
      index_d   = 3'd0;
      counter_d = 3'd0;
      timer_d   = '0;
    end
  end

  // Outputs are derived from the next state so they register alongside it.
  always_comb begin
    game_sel = '0;
    enable_d = '0;
    for (int i = 0; i < NUM_GAMES; i++) begin
      if (index_d == 3'(i)) begin
        game_sel = game_bits_in[20*i +: 20];
        if (state_d == PLAY) enable_d[i] = 1'b1;
      end
    end
    done_d = (state_d == DONE);
    case (state_d)
      PLAY:     bits_d = game_sel;
      WIN_HOLD: bits_d = WIN_PAT;
      DONE:     bits_d = DONE_PAT;
      default:  bits_d = IDLE_PAT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      index_q   <= 3'd0;
      counter_q <= 3'd0;
      timer_q   <= '0;
      enable_q  <= '0;
      bits_q    <= IDLE_PAT;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      counter_q <= counter_d;
      timer_q   <= timer_d;
      enable_q  <= enable_d;
      bits_q    <= bits_d;
      done_q    <= done_d;
    end
  end

  assign game_enable  = enable_q;
  assign game_counter = counter_q;
  assign game_index   = index_q;
  assign bits         = bits_q;
  assign all_done     = done_q;

endmodule
